// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: I-cache refill port, D-cache
// refill/write-back port and the shared off-chip memory port.
//   slave  : arbiter side (takes cache requests, drives memory command)
//   master : environment side (caches + memory)
// Signals:
//   i_mem_read/i_mem_addr -> ; i_mem_ready/i_mem_rdata <-
//   d_mem_read/d_mem_write/d_mem_addr/d_mem_wdata -> ; d_mem_ready/d_mem_rdata <-
//   mem_read/mem_write/mem_addr/mem_wdata <- ; mem_ready/mem_rdata ->
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned LINE_W = 128
);
    logic              i_mem_read;
    logic [ADDR_W-1:0] i_mem_addr;
    logic              i_mem_ready;
    logic [LINE_W-1:0] i_mem_rdata;

    logic              d_mem_read;
    logic              d_mem_write;
    logic [ADDR_W-1:0] d_mem_addr;
    logic [LINE_W-1:0] d_mem_wdata;
    logic              d_mem_ready;
    logic [LINE_W-1:0] d_mem_rdata;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [LINE_W-1:0] mem_rdata;

    modport slave (
        input  i_mem_read, i_mem_addr,
        output i_mem_ready, i_mem_rdata,
        input  d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
        output d_mem_ready, d_mem_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport master (
        output i_mem_read, i_mem_addr,
        input  i_mem_ready, i_mem_rdata,
        output d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
        input  d_mem_ready, d_mem_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the off-chip memory port between the I-cache and D-cache.
// One line transaction at a time: IDLE grants (round-robin on ties),
// BUSY holds the latched command until mem_ready, RESP returns a
// one-cycle ready pulse plus line data to the granted cache only.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   bus (slave)    : cache request/response ports and memory port
//   busy           : high whenever the FSM is not in IDLE
//   i_grant_cnt    : saturating count of I-cache grants
//   d_grant_cnt    : saturating count of D-cache grants
// All outputs are registered.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned LINE_W = 128,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_port_arbiter_if.slave bus,
    output logic             busy,
    output logic [CNT_W-1:0] i_grant_cnt,
    output logic [CNT_W-1:0] d_grant_cnt
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {REQ_I, REQ_D} req_t;

    localparam logic [LINE_W-1:0] ZERO_LINE = '0;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;

    state_t state, state_next;
    req_t   last_grant, cur_req, grant_req;
    logic   i_req, d_req, grant_vld;

    assign i_req = bus.i_mem_read;
    assign d_req = bus.d_mem_read | bus.d_mem_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        grant_vld  = 1'b0;
        grant_req  = REQ_I;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    grant_vld  = 1'b1;
                    state_next = BUSY;
                    if (i_req && d_req)
                        grant_req = (last_grant == REQ_I) ? REQ_D : REQ_I;
                    else
                        grant_req = d_req ? REQ_D : REQ_I;
                end
            end
            BUSY:    if (bus.mem_ready) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output/datapath registers are loaded from the same decisions the
    // next-state logic makes, so every output lines up with its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy            <= 1'b0;
            last_grant      <= REQ_I;
            cur_req         <= REQ_I;
            i_grant_cnt     <= '0;
            d_grant_cnt     <= '0;
            bus.mem_read    <= 1'b0;
            bus.mem_write   <= 1'b0;
            bus.mem_addr    <= ZERO_ADDR;
            bus.mem_wdata   <= ZERO_LINE;
            bus.i_mem_ready <= 1'b0;
            bus.i_mem_rdata <= ZERO_LINE;
            bus.d_mem_ready <= 1'b0;
            bus.d_mem_rdata <= ZERO_LINE;
        end else begin
            busy            <= (state_next != IDLE);
            bus.i_mem_ready <= 1'b0;
            bus.d_mem_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        cur_req    <= grant_req;
                        last_grant <= grant_req;
                        if (grant_req == REQ_D) begin
                            // read+write together is treated as a write
                            bus.mem_read  <= ~bus.d_mem_write;
                            bus.mem_write <= bus.d_mem_write;
                            bus.mem_addr  <= bus.d_mem_addr;
                            bus.mem_wdata <= bus.d_mem_write ? bus.d_mem_wdata : ZERO_LINE;
                            if (d_grant_cnt != '1) d_grant_cnt <= d_grant_cnt + 1'b1;
                        end else begin
                            bus.mem_read  <= 1'b1;
                            bus.mem_write <= 1'b0;
                            bus.mem_addr  <= bus.i_mem_addr;
                            bus.mem_wdata <= ZERO_LINE;
                            if (i_grant_cnt != '1) i_grant_cnt <= i_grant_cnt + 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (bus.mem_ready) begin
                        bus.mem_read  <= 1'b0;
                        bus.mem_write <= 1'b0;
                        if (cur_req == REQ_D) begin
                            bus.d_mem_ready <= 1'b1;
                            bus.d_mem_rdata <= bus.mem_write ? ZERO_LINE : bus.mem_rdata;
                        end else begin
                            bus.i_mem_ready <= 1'b1;
                            bus.i_mem_rdata <= bus.mem_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Outputs are checked and inputs
// driven on the falling clock edge; the DUT samples on the rising edge.
// Counters are built 4 bits wide so saturation is reached quickly.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 28;
    localparam int unsigned LINE_W = 128;
    localparam int unsigned CNT_W  = 4;

    logic             clk;
    logic             rst_n;
    logic             busy;
    logic [CNT_W-1:0] i_grant_cnt;
    logic [CNT_W-1:0] d_grant_cnt;

    int unsigned errors = 0;
    int unsigned checks = 0;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .busy        (busy),
        .i_grant_cnt (i_grant_cnt),
        .d_grant_cnt (d_grant_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // read and write together from the D-cache is an illegal request
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(bus.d_mem_read && bus.d_mem_write)) else begin
                errors++;
                $error("FAIL illegal_d_rw: d_mem_read=1 d_mem_write=1 required not both");
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.i_mem_read  = 1'b0;
        bus.i_mem_addr  = '0;
        bus.d_mem_read  = 1'b0;
        bus.d_mem_write = 1'b0;
        bus.d_mem_addr  = '0;
        bus.d_mem_wdata = '0;
        bus.mem_ready   = 1'b0;
        bus.mem_rdata   = '0;
    endtask

    task automatic do_reset();
        cyc();
        rst_n = 1'b0;
        clear_inputs();
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    logic [127:0] pat;
    logic [127:0] wpat;
    logic         exp_d;

    initial begin
        rst_n = 1'b0;
        clear_inputs();

        // ---- reset state
        cyc();
        cyc();
        chk("rst_mem_read",   128'(bus.mem_read),    128'(0));
        chk("rst_mem_write",  128'(bus.mem_write),   128'(0));
        chk("rst_mem_addr",   128'(bus.mem_addr),    128'(0));
        chk("rst_busy",       128'(busy),            128'(0));
        chk("rst_i_ready",    128'(bus.i_mem_ready), 128'(0));
        chk("rst_d_ready",    128'(bus.d_mem_ready), 128'(0));
        chk("rst_i_rdata",    128'(bus.i_mem_rdata), 128'(0));
        chk("rst_i_cnt",      128'(i_grant_cnt),     128'(0));
        chk("rst_d_cnt",      128'(d_grant_cnt),     128'(0));
        rst_n = 1'b1;

        // ---- 1: I-only read, memory acks in t3
        bus.i_mem_read = 1'b1;
        bus.i_mem_addr = 28'h0000010;
        cyc();  // t1
        chk("t1_mem_read", 128'(bus.mem_read),  128'(1));
        chk("t1_mem_addr", 128'(bus.mem_addr),  128'(28'h0000010));
        chk("t1_mem_write",128'(bus.mem_write), 128'(0));
        chk("t1_busy",     128'(busy),          128'(1));
        cyc();  // t2
        chk("t2_mem_read", 128'(bus.mem_read),  128'(1));
        chk("t2_i_ready",  128'(bus.i_mem_ready), 128'(0));
        cyc();  // t3
        chk("t3_mem_read", 128'(bus.mem_read),  128'(1));
        bus.mem_ready = 1'b1;
        bus.mem_rdata = {16{8'hA5}};
        cyc();  // t4
        bus.mem_ready = 1'b0;
        chk("t4_i_ready",  128'(bus.i_mem_ready), 128'(1));
        chk("t4_i_rdata",  bus.i_mem_rdata,       {16{8'hA5}});
        chk("t4_d_ready",  128'(bus.d_mem_ready), 128'(0));
        chk("t4_mem_read", 128'(bus.mem_read),    128'(0));
        chk("t4_i_cnt",    128'(i_grant_cnt),     128'(1));
        bus.i_mem_read = 1'b0;
        cyc();  // t5
        chk("t5_busy",     128'(busy),            128'(0));
        chk("t5_i_ready",  128'(bus.i_mem_ready), 128'(0));

        // ---- 2: simultaneous requests after reset, D wins first
        do_reset();
        bus.i_mem_read = 1'b1;
        bus.i_mem_addr = 28'h0000100;
        bus.d_mem_read = 1'b1;
        bus.d_mem_addr = 28'h0000200;
        cyc();
        chk("sim_first_addr", 128'(bus.mem_addr), 128'(28'h0000200));
        chk("sim_first_read", 128'(bus.mem_read), 128'(1));
        chk("sim_d_cnt1",     128'(d_grant_cnt),  128'(1));
        chk("sim_i_cnt0",     128'(i_grant_cnt),  128'(0));
        bus.mem_ready = 1'b1;
        bus.mem_rdata = {16{8'h5A}};
        cyc();
        bus.mem_ready = 1'b0;
        chk("sim_d_ready", 128'(bus.d_mem_ready), 128'(1));
        chk("sim_d_rdata", bus.d_mem_rdata,       {16{8'h5A}});
        chk("sim_i_quiet", 128'(bus.i_mem_ready), 128'(0));
        bus.d_mem_read = 1'b0;
        cyc();
        chk("sim_idle_busy", 128'(busy),         128'(0));
        chk("sim_idle_read", 128'(bus.mem_read), 128'(0));
        cyc();
        chk("sim_second_addr", 128'(bus.mem_addr), 128'(28'h0000100));
        chk("sim_second_read", 128'(bus.mem_read), 128'(1));
        bus.mem_ready = 1'b1;
        bus.mem_rdata = {16{8'h3C}};
        cyc();
        bus.mem_ready = 1'b0;
        chk("sim_i_ready", 128'(bus.i_mem_ready), 128'(1));
        chk("sim_i_rdata", bus.i_mem_rdata,       {16{8'h3C}});
        bus.i_mem_read = 1'b0;
        cyc();
        chk("sim_i_cnt", 128'(i_grant_cnt), 128'(1));
        chk("sim_d_cnt", 128'(d_grant_cnt), 128'(1));

        // ---- 3: round-robin under continuous requests: D,I,D,I,D,I
        bus.i_mem_read = 1'b1;
        bus.i_mem_addr = 28'h0000111;
        bus.d_mem_read = 1'b1;
        bus.d_mem_addr = 28'h0000222;
        for (int k = 0; k < 6; k++) begin
            exp_d = ((k % 2) == 0);
            pat   = {16{8'h10 + 8'(k)}};
            cyc();  // BUSY
            chk($sformatf("rr%0d_addr", k), 128'(bus.mem_addr),
                128'(exp_d ? 28'h0000222 : 28'h0000111));
            bus.mem_ready = 1'b1;
            bus.mem_rdata = pat;
            cyc();  // RESP
            bus.mem_ready = 1'b0;
            chk($sformatf("rr%0d_d_ready", k), 128'(bus.d_mem_ready), 128'(exp_d));
            chk($sformatf("rr%0d_i_ready", k), 128'(bus.i_mem_ready), 128'(!exp_d));
            chk($sformatf("rr%0d_rdata", k),
                exp_d ? bus.d_mem_rdata : bus.i_mem_rdata, pat);
            cyc();  // IDLE
        end
        bus.i_mem_read = 1'b0;
        bus.d_mem_read = 1'b0;
        chk("rr_i_cnt", 128'(i_grant_cnt), 128'(4));
        chk("rr_d_cnt", 128'(d_grant_cnt), 128'(4));

        // ---- 4: D write-back, memory acks on 5th BUSY cycle
        wpat = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
        bus.d_mem_write = 1'b1;
        bus.d_mem_addr  = 28'h0000333;
        bus.d_mem_wdata = wpat;
        for (int j = 1; j <= 5; j++) begin
            cyc();
            chk($sformatf("wb%0d_write", j), 128'(bus.mem_write),   128'(1));
            chk($sformatf("wb%0d_read", j),  128'(bus.mem_read),    128'(0));
            chk($sformatf("wb%0d_wdata", j), bus.mem_wdata,         wpat);
            chk($sformatf("wb%0d_i_rdy", j), 128'(bus.i_mem_ready), 128'(0));
            if (j == 5) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = '1;
            end
        end
        cyc();  // RESP
        bus.mem_ready = 1'b0;
        chk("wb_d_ready", 128'(bus.d_mem_ready), 128'(1));
        chk("wb_d_rdata", bus.d_mem_rdata,       128'(0));
        chk("wb_i_ready", 128'(bus.i_mem_ready), 128'(0));
        chk("wb_cmd_off", 128'(bus.mem_write),   128'(0));
        bus.d_mem_write = 1'b0;
        cyc();
        chk("wb_d_pulse_end", 128'(bus.d_mem_ready), 128'(0));
        chk("wb_d_cnt",       128'(d_grant_cnt),     128'(5));

        // ---- 5: asynchronous reset while BUSY
        bus.i_mem_read = 1'b1;
        bus.i_mem_addr = 28'h0000444;
        cyc();
        chk("ar_busy_read", 128'(bus.mem_read), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("ar_read_drop",  128'(bus.mem_read),  128'(0));
        chk("ar_write_drop", 128'(bus.mem_write), 128'(0));
        chk("ar_busy_drop",  128'(busy),          128'(0));
        chk("ar_i_cnt",      128'(i_grant_cnt),   128'(0));
        chk("ar_d_cnt",      128'(d_grant_cnt),   128'(0));
        bus.i_mem_read = 1'b0;
        bus.mem_ready  = 1'b1;
        cyc();
        chk("ar_no_i_ready", 128'(bus.i_mem_ready), 128'(0));
        chk("ar_no_d_ready", 128'(bus.d_mem_ready), 128'(0));
        rst_n = 1'b1;
        bus.mem_ready  = 1'b0;
        bus.i_mem_read = 1'b1;
        bus.i_mem_addr = 28'h0000555;
        cyc();
        chk("ar_new_addr",  128'(bus.mem_addr), 128'(28'h0000555));
        chk("ar_new_i_cnt", 128'(i_grant_cnt),  128'(1));
        bus.mem_ready = 1'b1;
        bus.mem_rdata = {16{8'hC3}};
        cyc();
        bus.mem_ready  = 1'b0;
        bus.i_mem_read = 1'b0;
        chk("ar_new_ready", 128'(bus.i_mem_ready), 128'(1));
        chk("ar_new_rdata", bus.i_mem_rdata,       {16{8'hC3}});
        cyc();

        // ---- 6: counter saturation (2^CNT_W + 3 grants) and stray mem_ready
        do_reset();
        for (int k = 0; k < 19; k++) begin
            bus.i_mem_read = 1'b1;
            bus.i_mem_addr = 28'(k);
            cyc();  // BUSY
            bus.mem_ready = 1'b1;
            cyc();  // RESP
            bus.mem_ready  = 1'b0;
            bus.i_mem_read = 1'b0;
            chk($sformatf("sat%0d_cnt", k), 128'(i_grant_cnt),
                128'(((k + 1) > 15) ? 15 : (k + 1)));
            cyc();  // IDLE
        end
        chk("sat_final", 128'(i_grant_cnt), 128'(4'hF));
        bus.mem_ready = 1'b1;
        cyc();
        chk("stray_i_ready", 128'(bus.i_mem_ready), 128'(0));
        chk("stray_d_ready", 128'(bus.d_mem_ready), 128'(0));
        chk("stray_busy",    128'(busy),            128'(0));
        cyc();
        bus.mem_ready = 1'b0;
        chk("stray_i_ready2", 128'(bus.i_mem_ready), 128'(0));
        chk("stray_read",     128'(bus.mem_read),    128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
